packet_merger: RTL and testbench
================================

PACKET_MERGER -- requirements
Module: packet_merger

Interface
REQ-001 The block SHALL have parameter SEGMENT_SIZE, default 8, bits per input segment.
REQ-002 The block SHALL have parameter SEGMENT_COUNT, default 4, segments per output word; legal values are 2 or more.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, output word buffer depth; legal values are powers of 2, 2 or more.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_full, output, 1 bit: input cannot accept a segment this cycle.
REQ-007 The block SHALL have port in_shift, input, 1 bit: push in_data/in_end this cycle.
REQ-008 The block SHALL have port in_data, input, SEGMENT_SIZE bits: segment payload.
REQ-009 The block SHALL have port in_end, input, 1 bit: this segment is the last of its packet.
REQ-010 The block SHALL have port out_pop, input, 1 bit: consume the head word this cycle.
REQ-011 The block SHALL have port out_nempty, output, 1 bit: a head word is available.
REQ-012 The block SHALL have port out_data, output, SEGMENT_SIZE*SEGMENT_COUNT bits: head word payload.
REQ-013 The block SHALL have port out_end, output, 1 bit: the head word closes a packet.
REQ-014 The block SHALL have port out_count, output, $clog2(SEGMENT_COUNT)+1 bits: number of valid segments in the head word, 1..SEGMENT_COUNT.

Function
REQ-015 An accepted segment SHALL be one where in_shift=1 and in_full=0 at a rising edge; in_shift while in_full=1 SHALL be ignored with no state change.
REQ-016 Segments SHALL pack LSB-first: the k-th accepted segment of a word lands in bits [k*SEGMENT_SIZE +: SEGMENT_SIZE], with k starting at 0.
REQ-017 An accumulator index SHALL count accepted segments 0..SEGMENT_COUNT-1.
REQ-018 A word SHALL complete on the accepted segment that either has in_end=1 or brings the index to SEGMENT_COUNT.
REQ-019 On completion, the word SHALL be written to the output FIFO in the same edge, and the accumulator SHALL clear the index to 0 and the payload to 0.
REQ-020 A word completed by in_end SHALL have out_end=1; a word completed by filling all segments without in_end SHALL have out_end=0.
REQ-021 When a word's final segment carries in_end=1 (index=SEGMENT_COUNT-1), the block SHALL emit exactly one word with out_end=1, and SHALL NOT emit an empty trailing word.
REQ-022 In a short word, unwritten segments SHALL read as 0, and out_count SHALL equal the number of accepted segments in that word.
REQ-023 in_full SHALL be 1 exactly when the output FIFO holds FIFO_DEPTH words, and SHALL derive from registered state only; a same-cycle out_pop SHALL NOT clear it that cycle.
REQ-024 Latency SHALL be: the completing segment accepted at edge N gives out_nempty=1 and valid out_data, out_end and out_count after edge N, i.e. one cycle.
REQ-025 out_data, out_end and out_count SHALL reflect the FIFO head whenever out_nempty=1; their values while out_nempty=0 are don't-care.
REQ-026 out_pop=1 while out_nempty=1 SHALL remove the head at the edge; out_pop while empty SHALL be ignored.
REQ-027 A simultaneous completion and pop SHALL both take effect, leaving the FIFO occupancy unchanged.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL be tracked so that full and empty are unambiguous.
REQ-029 A partial word in the accumulator SHALL NOT be visible at the output until it completes; the block SHALL have no timeout flush.

Reset
REQ-030 rst_n=0 SHALL immediately and asynchronously clear the accumulator index and payload, and set the FIFO pointers and occupancy to 0.
REQ-031 During reset the outputs SHALL be in_full=0 and out_nempty=0, and out_data, out_end and out_count SHALL be 0.
REQ-032 Reset asserted mid-packet SHALL discard the partial word and all buffered words; the first segment accepted after release SHALL land in segment 0.
REQ-033 Release of rst_n SHALL be synchronous to clk externally; the block SHALL accept segments from the first edge after release.

Verification
REQ-034 Full word (defaults): shift 0x11, 0x22, 0x33, 0x44 with in_end=0 -> one word: out_data=0x44332211, out_end=0, out_count=4.
REQ-035 Short packet: shift 0xAA, then 0xBB with in_end=1 -> out_data=0x0000BBAA, out_end=1, out_count=2; the next packet starts at segment 0.
REQ-036 Boundary end: shift 4 segments 0x01..0x04 with the 4th carrying in_end=1 -> exactly one word 0x04030201, out_end=1, count=4; no extra word follows.
REQ-037 Backpressure: no pops, shift 20 single-segment in_end=1 packets -> in_full=1 after 4 words, later shifts are dropped, and popping yields exactly the first 4 values in order.
REQ-038 Reset mid-packet: shift 0x55, 0x66, then pulse rst_n low, then shift 0x77 with in_end=1 -> a single word 0x00000077, count=1, out_end=1.
REQ-039 Random soak: feed the same random stimulus as the packet_splitter bench through packet_splitter into packet_merger -> the words and end flags that come out match the words fed in, with the original segment counts restored.

Source files
------------

// File: rtl/packet_merger.sv
// Packs fixed-width input segments LSB-first into wide words and queues them
// in a small FIFO. A word closes on a packet end or when every segment is filled.
module packet_merger #(
  parameter int SEGMENT_SIZE  = 8,
  parameter int SEGMENT_COUNT = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  output logic                                    in_full,
  input  logic                                    in_shift,
  input  logic [SEGMENT_SIZE-1:0]                 in_data,
  input  logic                                    in_end,
  input  logic                                    out_pop,
  output logic                                    out_nempty,
  output logic [SEGMENT_SIZE*SEGMENT_COUNT-1:0]   out_data,
  output logic                                    out_end,
  output logic [$clog2(SEGMENT_COUNT):0]          out_count
);

  localparam int CNT_W  = $clog2(SEGMENT_COUNT) + 1;
  localparam int WORD_W = SEGMENT_SIZE * SEGMENT_COUNT;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  logic [CNT_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_acc;

  logic [WORD_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_end  [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_mem_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_occ;

  logic              w_full;
  logic              w_nempty;
  logic              w_accept;
  logic              w_pop;
  logic              w_last;
  logic              w_push;
  logic [CNT_W-1:0]  w_cnt;
  logic [WORD_W-1:0] w_word;

  assign w_full   = (r_occ == (PTR_W+1)'(FIFO_DEPTH));
  assign w_nempty = (r_occ != '0);
  assign w_accept = in_shift & ~w_full;
  assign w_pop    = out_pop & w_nempty;
  assign w_last   = in_end | (r_idx == CNT_W'(SEGMENT_COUNT - 1));
  assign w_push   = w_accept & w_last;
  assign w_cnt    = r_idx + CNT_W'(1);

  // Accumulator contents with the incoming segment merged into its slot.
  always_comb begin
    w_word = r_acc;
    for (int k = 0; k < SEGMENT_COUNT; k++) begin
      if (r_idx == CNT_W'(k)) begin
        w_word[k*SEGMENT_SIZE +: SEGMENT_SIZE] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_idx <= '0;
        r_acc <= '0;
      end else begin
        r_idx <= w_cnt;
        r_acc <= w_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_end[r_wr_ptr]  <= in_end;
      r_mem_cnt[r_wr_ptr]  <= w_cnt;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; r_occ keeps full/empty distinct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (PTR_W+1)'(1);
        2'b01:   r_occ <= r_occ - (PTR_W+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Head fields are forced to zero when empty so reset shows clean outputs.
  assign in_full    = w_full;
  assign out_nempty = w_nempty;
  assign out_data   = w_nempty ? r_mem_data[r_rd_ptr] : '0;
  assign out_end    = w_nempty ? r_mem_end[r_rd_ptr]  : 1'b0;
  assign out_count  = w_nempty ? r_mem_cnt[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_packet_merger.sv
// Directed and random checks of packet_merger against a queue-based model
// of packets, words and the output buffer.
module tb_packet_merger;

  localparam int SS = 8;
  localparam int SC = 4;
  localparam int FD = 4;
  localparam int WW = SS * SC;
  localparam int CW = $clog2(SC) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_full;
  logic          in_shift;
  logic [SS-1:0] in_data;
  logic          in_end;
  logic          out_pop;
  logic          out_nempty;
  logic [WW-1:0] out_data;
  logic          out_end;
  logic [CW-1:0] out_count;

  packet_merger #(
    .SEGMENT_SIZE(SS), .SEGMENT_COUNT(SC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_full(in_full), .in_shift(in_shift),
    .in_data(in_data), .in_end(in_end), .out_pop(out_pop),
    .out_nempty(out_nempty), .out_data(out_data), .out_end(out_end),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] d;
    bit            e;
    int            c;
  } word_t;

  word_t         m_q[$];
  logic [SS-1:0] m_seg[$];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one rising edge, applied in terms of packets and queues.
  task automatic model_edge(input bit sh, input logic [SS-1:0] d, input bit e, input bit p);
    word_t w;
    bit full;
    full = (m_q.size() == FD);
    if (p && m_q.size() > 0) m_q.delete(0);
    if (sh && !full) begin
      m_seg.push_back(d);
      if (e || m_seg.size() == SC) begin
        w.d = '0;
        for (int k = 0; k < m_seg.size(); k++) w.d = w.d | (WW'(m_seg[k]) << (SS * k));
        w.e = e;
        w.c = m_seg.size();
        m_q.push_back(w);
        m_seg.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_full", 64'(in_full), 64'(m_q.size() == FD));
    chk("out_nempty", 64'(out_nempty), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(m_q[0].d));
      chk("out_end", 64'(out_end), 64'(m_q[0].e));
      chk("out_count", 64'(out_count), 64'(m_q[0].c));
    end
  endtask

  task automatic step(input bit sh, input logic [SS-1:0] d, input bit e, input bit p);
    @(negedge clk);
    check_outputs();
    in_shift = sh;
    in_data  = d;
    in_end   = e;
    out_pop  = p;
    @(posedge clk);
    model_edge(sh, d, e, p);
  endtask

  task automatic expect_head(input string tag, input logic [WW-1:0] d, input bit e, input int c);
    @(negedge clk);
    in_shift = 1'b0;
    in_end   = 1'b0;
    out_pop  = 1'b0;
    chk({tag, "_nempty"}, 64'(out_nempty), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_end"}, 64'(out_end), 64'(e));
    chk({tag, "_count"}, 64'(out_count), 64'(c));
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    in_shift = 1'b0;
    in_end   = 1'b0;
    out_pop  = 1'b0;
    chk({tag, "_nempty"}, 64'(out_nempty), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_full"}, 64'(in_full), 64'd0);
    chk({tag, "_nempty"}, 64'(out_nempty), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_end"}, 64'(out_end), 64'd0);
    chk({tag, "_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_shift = 1'b0;
    in_data  = '0;
    in_end   = 1'b0;
    out_pop  = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full word without an end marker.
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    expect_head("full_word", 32'h44332211, 0, 4);
    step(0, 8'h00, 0, 1);
    expect_empty("full_word_popped");

    // Short packet, then the following packet restarts at segment 0.
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 1, 0);
    expect_head("short", 32'h0000BBAA, 1, 2);
    step(0, 8'h00, 0, 1);
    step(1, 8'hCC, 1, 0);
    expect_head("next_pkt", 32'h000000CC, 1, 1);
    step(0, 8'h00, 0, 1);

    // End marker on the last slot yields one word and no empty trailer.
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h04, 1, 0);
    expect_head("boundary", 32'h04030201, 1, 4);
    step(0, 8'h00, 0, 1);
    expect_empty("boundary_no_extra");

    // Backpressure: only the first FD packets survive.
    for (int i = 0; i < 20; i++) step(1, 8'(i + 1), 1, 0);
    @(negedge clk);
    chk("bp_in_full", 64'(in_full), 64'd1);
    for (int i = 0; i < FD; i++) begin
      expect_head("bp_pop", WW'(i + 1), 1, 1);
      step(0, 8'h00, 0, 1);
    end
    expect_empty("bp_drained");

    // Reset mid-packet discards the partial word.
    step(1, 8'h55, 0, 0);
    step(1, 8'h66, 0, 0);
    @(negedge clk);
    in_shift = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_q.delete();
    m_seg.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h77, 1, 0);
    expect_head("after_reset", 32'h00000077, 1, 1);
    step(0, 8'h00, 0, 1);

    // Random soak with concurrent pushes and pops.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1);
    end
    repeat (FD + 2) step(0, 8'h00, 0, 1);
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
